// File: rtl/bank_access_arbiter.sv
// rtl/bank_access_arbiter.sv - two-port round-robin arbiter in front of a single-ported data bank
//
// Purpose: arbitrates host and NTT-core requests onto one 128x14 bank. The write
// port and the read port each run their own two-way round-robin, with grants
// issued in the same cycle as the request. Reads come back two cycles after the
// grant, tagged to the requester, and are forwarded from a same-cycle write to
// the same address because the bank returns the old contents in that case.
//
// Ports:
//   clk, rst_n                        clock, synchronous active-low reset
//   h_wreq/h_waddr/h_wdata            host write request
//   h_rreq/h_raddr                    host read request
//   c_wreq/c_waddr/c_wdata            core write request
//   c_rreq/c_raddr                    core read request
//   h_wgnt/h_rgnt/c_wgnt/c_rgnt       combinational grants
//   b_A1/b_D/b_IWEN                   bank write address, data, write enable
//   b_A2/b_IREN/b_IEN                 bank read address, read enable, bank enable
//   b_Q                               bank read data, one cycle after b_IREN
//   h_rvalid/c_rvalid/rdata           registered read return
`timescale 1ns/1ps

module bank_access_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        h_wreq,
  input  logic [6:0]  h_waddr,
  input  logic [13:0] h_wdata,
  input  logic        h_rreq,
  input  logic [6:0]  h_raddr,
  input  logic        c_wreq,
  input  logic [6:0]  c_waddr,
  input  logic [13:0] c_wdata,
  input  logic        c_rreq,
  input  logic [6:0]  c_raddr,
  output logic        h_wgnt,
  output logic        h_rgnt,
  output logic        c_wgnt,
  output logic        c_rgnt,
  output logic [6:0]  b_A1,
  output logic [13:0] b_D,
  output logic        b_IWEN,
  output logic [6:0]  b_A2,
  output logic        b_IREN,
  output logic        b_IEN,
  input  logic [13:0] b_Q,
  output logic        h_rvalid,
  output logic        c_rvalid,
  output logic [13:0] rdata
);

  // Round-robin pointers: 1 means the core was granted last on that port.
  logic        wlast_c_q, wlast_c_d;
  logic        rlast_c_q, rlast_c_d;
  // Held bank address/data so the bank pins stay stable when idle.
  logic [6:0]  a1_q, a1_d;
  logic [13:0] d_q, d_d;
  logic [6:0]  a2_q, a2_d;
  // Read pipeline stage 1 (bank access cycle): valid, tag, forwarding capture.
  logic        s1_vld_q, s1_vld_d;
  logic        s1_core_q, s1_core_d;
  logic        s1_fwd_q, s1_fwd_d;
  logic [13:0] s1_fwd_data_q, s1_fwd_data_d;
  // Read pipeline stage 2 (return registers).
  logic        h_rvalid_q, h_rvalid_d;
  logic        c_rvalid_q, c_rvalid_d;
  logic [13:0] rdata_q, rdata_d;

  logic        wr_gnt, rd_gnt;
  logic [6:0]  wr_addr, rd_addr;
  logic [13:0] wr_data;

  always_comb begin
    // On a conflict the side that was not granted last wins; reset blocks all grants.
    h_wgnt = rst_n & h_wreq & (~c_wreq | wlast_c_q);
    c_wgnt = rst_n & c_wreq & ~h_wgnt;
    h_rgnt = rst_n & h_rreq & (~c_rreq | rlast_c_q);
    c_rgnt = rst_n & c_rreq & ~h_rgnt;

    wr_gnt  = h_wgnt | c_wgnt;
    rd_gnt  = h_rgnt | c_rgnt;
    wr_addr = h_wgnt ? h_waddr : c_waddr;
    wr_data = h_wgnt ? h_wdata : c_wdata;
    rd_addr = h_rgnt ? h_raddr : c_raddr;

    b_IWEN = wr_gnt;
    b_IREN = rd_gnt;
    b_IEN  = wr_gnt | rd_gnt;
    b_A1   = wr_gnt ? wr_addr : a1_q;
    b_D    = wr_gnt ? wr_data : d_q;
    b_A2   = rd_gnt ? rd_addr : a2_q;

    wlast_c_d = wr_gnt ? c_wgnt : wlast_c_q;
    rlast_c_d = rd_gnt ? c_rgnt : rlast_c_q;
    a1_d      = b_A1;
    d_d       = b_D;
    a2_d      = b_A2;

    s1_vld_d      = rd_gnt;
    s1_core_d     = c_rgnt;
    // Read-first bank: a same-cycle write to the read address must be returned instead of b_Q.
    s1_fwd_d      = wr_gnt & rd_gnt & (wr_addr == rd_addr);
    s1_fwd_data_d = wr_data;

    h_rvalid_d = s1_vld_q & ~s1_core_q;
    c_rvalid_d = s1_vld_q & s1_core_q;
    rdata_d    = rdata_q;
    if (s1_vld_q) begin
      rdata_d = s1_fwd_q ? s1_fwd_data_q : b_Q;
    end

    h_rvalid = h_rvalid_q;
    c_rvalid = c_rvalid_q;
    rdata    = rdata_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wlast_c_q     <= 1'b1;
      rlast_c_q     <= 1'b1;
      a1_q          <= '0;
      d_q           <= '0;
      a2_q          <= '0;
      s1_vld_q      <= 1'b0;
      s1_core_q     <= 1'b0;
      s1_fwd_q      <= 1'b0;
      s1_fwd_data_q <= '0;
      h_rvalid_q    <= 1'b0;
      c_rvalid_q    <= 1'b0;
      rdata_q       <= '0;
    end else begin
      wlast_c_q     <= wlast_c_d;
      rlast_c_q     <= rlast_c_d;
      a1_q          <= a1_d;
      d_q           <= d_d;
      a2_q          <= a2_d;
      s1_vld_q      <= s1_vld_d;
      s1_core_q     <= s1_core_d;
      s1_fwd_q      <= s1_fwd_d;
      s1_fwd_data_q <= s1_fwd_data_d;
      h_rvalid_q    <= h_rvalid_d;
      c_rvalid_q    <= c_rvalid_d;
      rdata_q       <= rdata_d;
    end
  end

endmodule

// File: tb/tb_bank_access_arbiter.sv
// tb/tb_bank_access_arbiter.sv - scoreboard bench for bank_access_arbiter with a read-first bank model
`timescale 1ns/1ps

module tb_bank_access_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        h_wreq, h_rreq, c_wreq, c_rreq;
  logic [6:0]  h_waddr, h_raddr, c_waddr, c_raddr;
  logic [13:0] h_wdata, c_wdata;
  logic        h_wgnt, h_rgnt, c_wgnt, c_rgnt;
  logic [6:0]  b_A1, b_A2;
  logic [13:0] b_D, b_Q, rdata;
  logic        b_IWEN, b_IREN, b_IEN, h_rvalid, c_rvalid;

  bank_access_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .h_wreq(h_wreq), .h_waddr(h_waddr), .h_wdata(h_wdata),
    .h_rreq(h_rreq), .h_raddr(h_raddr),
    .c_wreq(c_wreq), .c_waddr(c_waddr), .c_wdata(c_wdata),
    .c_rreq(c_rreq), .c_raddr(c_raddr),
    .h_wgnt(h_wgnt), .h_rgnt(h_rgnt), .c_wgnt(c_wgnt), .c_rgnt(c_rgnt),
    .b_A1(b_A1), .b_D(b_D), .b_IWEN(b_IWEN),
    .b_A2(b_A2), .b_IREN(b_IREN), .b_IEN(b_IEN),
    .b_Q(b_Q),
    .h_rvalid(h_rvalid), .c_rvalid(c_rvalid), .rdata(rdata)
  );

  // Attached bank: read-first, registered output, enabled by b_IEN.
  logic [13:0] bank_mem [128];
  bit          bank_init;
  always @(posedge clk) begin
    if (!bank_init) begin
      for (int i = 0; i < 128; i++) bank_mem[i] <= 14'(i * 97 + 5);
      bank_init <= 1'b1;
    end else if (b_IEN) begin
      if (b_IREN) b_Q <= bank_mem[b_A2];
      if (b_IWEN) bank_mem[b_A1] <= b_D;
    end
  end

  int cyc;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: memory contents as seen by a read granted in a given cycle
  // (all writes granted in that cycle or earlier), plus per-port last-winner.
  logic [13:0] ref_mem [128];
  bit          wlast_c, rlast_c;
  logic [6:0]  hold_a1, hold_a2;
  logic [13:0] hold_d;

  typedef struct {
    bit          core;
    logic [13:0] data;
    int          due;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  int n_checks = 0;
  int n_pass   = 0;
  bit got_hw, got_cw, got_hr, got_cr;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // One clock cycle: inputs are already driven; check grants and bank pins at
  // the negedge, advance the model and queue any read return.
  task automatic step();
    bit ehw, ecw, ehr, ecr;
    logic [6:0] ra;
    @(negedge clk);
    got_hw = h_wgnt; got_cw = c_wgnt; got_hr = h_rgnt; got_cr = c_rgnt;
    if (!rst_n) begin
      chk("gnt_in_reset", {25'd0, h_wgnt, c_wgnt, h_rgnt, c_rgnt, b_IWEN, b_IREN, b_IEN}, 32'd0);
      wlast_c = 1'b1; rlast_c = 1'b1;
      hold_a1 = '0; hold_a2 = '0; hold_d = '0;
      sb.delete();
    end else begin
      if (h_wreq && c_wreq) begin ehw = wlast_c; ecw = !wlast_c; end
      else begin ehw = h_wreq; ecw = c_wreq; end
      if (h_rreq && c_rreq) begin ehr = rlast_c; ecr = !rlast_c; end
      else begin ehr = h_rreq; ecr = c_rreq; end
      chk("wgnt", {30'd0, h_wgnt, c_wgnt}, {30'd0, ehw, ecw});
      chk("rgnt", {30'd0, h_rgnt, c_rgnt}, {30'd0, ehr, ecr});
      chk("enables", {29'd0, b_IWEN, b_IREN, b_IEN},
          {29'd0, ehw | ecw, ehr | ecr, ehw | ecw | ehr | ecr});
      if (ehw || ecw) begin
        hold_a1 = ehw ? h_waddr : c_waddr;
        hold_d  = ehw ? h_wdata : c_wdata;
        ref_mem[hold_a1] = hold_d;
        wlast_c = ecw;
      end
      chk("b_A1", {25'd0, b_A1}, {25'd0, hold_a1});
      chk("b_D", {18'd0, b_D}, {18'd0, hold_d});
      if (ehr || ecr) begin
        ra = ehr ? h_raddr : c_raddr;
        hold_a2 = ra;
        sb.push_back('{core: ecr, data: ref_mem[ra], due: cyc + 2});
        rlast_c = ecr;
      end
      chk("b_A2", {25'd0, b_A2}, {25'd0, hold_a2});
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: every cycle out of reset the return strobes must match the queue head.
  always @(negedge clk) begin
    if (rst_n && cyc > 0) begin
      if (sb.size() > 0 && sb[0].due == cyc) begin
        mon_e = sb.pop_front();
        chk("rvalid_tag", {30'd0, h_rvalid, c_rvalid}, mon_e.core ? 32'd1 : 32'd2);
        chk("rdata", {18'd0, rdata}, {18'd0, mon_e.data});
      end else begin
        chk("no_rvalid", {30'd0, h_rvalid, c_rvalid}, 32'd0);
      end
    end
  end

  task automatic idle();
    h_wreq = 0; c_wreq = 0; h_rreq = 0; c_rreq = 0;
  endtask

  initial begin
    logic [3:0] seq;
    for (int i = 0; i < 128; i++) ref_mem[i] = 14'(i * 97 + 5);
    rst_n = 0;
    h_waddr = 0; h_wdata = 0; h_raddr = 0; c_waddr = 0; c_wdata = 0; c_raddr = 0;
    idle();
    #1;
    // Requests during reset must not be granted.
    h_wreq = 1; c_rreq = 1;
    step(); step();
    idle();
    rst_n = 1;
    chk("reset_rdata", {18'd0, rdata}, 32'd0);
    chk("reset_rvalid", {30'd0, h_rvalid, c_rvalid}, 32'd0);

    // Write-port conflict held four cycles: host, core, host, core.
    h_wreq = 1; h_waddr = 10; h_wdata = 14'h0AAA;
    c_wreq = 1; c_waddr = 20; c_wdata = 14'h1555;
    seq = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      seq = {seq[2:0], got_hw};
    end
    chk("rr_seq", {28'd0, seq}, 32'hA);
    idle();

    // Core write then core read of the same address one cycle later.
    c_wreq = 1; c_waddr = 5; c_wdata = 14'h1ABC; step(); idle();
    c_rreq = 1; c_raddr = 5; step(); idle();
    step(); step(); step();

    // Same-cycle write/read collision must forward the new data.
    h_wreq = 1; h_waddr = 9; h_wdata = 14'h3FFF; step(); idle(); step();
    h_wreq = 1; h_wdata = 14'h0123; c_rreq = 1; c_raddr = 9; step(); idle();
    step(); step(); step();

    // Back-to-back host reads at full throughput.
    for (int i = 0; i < 4; i++) begin
      h_rreq = 1; h_raddr = 7'(i); step();
    end
    idle();
    step(); step(); step();

    // Reset with a read in flight: no return, pointers restored.
    h_wreq = 1; c_wreq = 1; c_rreq = 1; h_rreq = 1; step();
    idle(); c_rreq = 1; c_raddr = 1; step(); idle();
    rst_n = 0; step(); rst_n = 1;
    chk("rdata_after_reset", {18'd0, rdata}, 32'd0);
    h_wreq = 1; c_wreq = 1; h_rreq = 1; c_rreq = 1; step();
    chk("host_wins_wr", {31'd0, got_hw}, 32'd1);
    chk("host_wins_rd", {31'd0, got_hr}, 32'd1);
    idle(); step(); step(); step();

    // Random concurrent traffic; requesters hold until granted.
    for (int n = 0; n < 3000; n++) begin
      if (!h_wreq || got_hw) begin
        h_wreq = ($urandom_range(0, 2) != 0); h_waddr = 7'($urandom_range(0, 7)); h_wdata = 14'($urandom);
      end
      if (!c_wreq || got_cw) begin
        c_wreq = ($urandom_range(0, 2) != 0); c_waddr = 7'($urandom_range(0, 7)); c_wdata = 14'($urandom);
      end
      if (!h_rreq || got_hr) begin
        h_rreq = ($urandom_range(0, 2) != 0); h_raddr = 7'($urandom_range(0, 7));
      end
      if (!c_rreq || got_cr) begin
        c_rreq = ($urandom_range(0, 2) != 0); c_raddr = 7'($urandom_range(0, 7));
      end
      step();
    end
    idle();
    for (int i = 0; i < 4; i++) step();
    chk("sb_drained", sb.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
